fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between two packet requesters, the write arbiter and a downstream FIFO.
// master = requester/FIFO side that drives valid/data/last/full; slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int B = 8
);
    logic         req0_valid;
    logic [B-1:0] req0_data;
    logic         req0_last;
    logic         req0_ready;
    logic         req1_valid;
    logic [B-1:0] req1_data;
    logic         req1_last;
    logic         req1_ready;
    logic         fifo_full;
    logic         fifo_wr;
    logic [B-1:0] fifo_wdata;
    logic [1:0]   grant;
    logic         abort;
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output fifo_full,
        input  req0_ready, req1_ready, fifo_wr, fifo_wdata, grant, abort, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  fifo_full,
        output req0_ready, req1_ready, fifo_wr, fifo_wdata, grant, abort, cnt0, cnt1
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester packet arbiter in front of a FIFO write port, round-robin on ties, idle timeout.
// Optional per-requester accepted-word counters are built only when FIFO_ARB_CNT_EN is defined.
module fifo_wr_arbiter #(
    parameter int B  = 8,
    parameter int TO = 16
) (
    input  logic              clk,
    input  logic              reset,
    fifo_wr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] TO_LIM = 8'(TO - 1);

    state_e     state_q;
    logic       last_q;
    logic [7:0] tmo_q;
    logic       abort_q;

    logic         own_valid_s;
    logic         own_last_s;
    logic [B-1:0] own_data_s;
    logic         rdy0_s;
    logic         rdy1_s;
    logic         xfer_s;

    // Steer the owning requester onto the FIFO port; everything is forced quiet during reset.
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = '0;
        rdy0_s      = 1'b0;
        rdy1_s      = 1'b0;
        if (!reset) begin
            case (state_q)
                OWN0: begin
                    own_valid_s = bus.req0_valid;
                    own_last_s  = bus.req0_last;
                    own_data_s  = bus.req0_data;
                    rdy0_s      = ~bus.fifo_full;
                end
                OWN1: begin
                    own_valid_s = bus.req1_valid;
                    own_last_s  = bus.req1_last;
                    own_data_s  = bus.req1_data;
                    rdy1_s      = ~bus.fifo_full;
                end
                default: begin
                    own_valid_s = 1'b0;
                end
            endcase
        end else begin
            own_valid_s = 1'b0;
        end
    end

    assign xfer_s         = own_valid_s & ~bus.fifo_full;
    assign bus.req0_ready = rdy0_s;
    assign bus.req1_ready = rdy1_s;
    assign bus.fifo_wr    = xfer_s;
    assign bus.fifo_wdata = own_data_s;
    assign bus.abort      = abort_q;
    assign bus.grant      = (state_q == OWN0) ? 2'b01 :
                            (state_q == OWN1) ? 2'b10 : 2'b00;

    // Ownership FSM: last_q=1 means requester 1 was served last, so requester 0 wins the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            tmo_q   <= 8'd0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= 8'd0;
                    if (bus.req0_valid && bus.req1_valid) begin
                        state_q <= last_q ? OWN0 : OWN1;
                    end else if (bus.req0_valid) begin
                        state_q <= OWN0;
                    end else if (bus.req1_valid) begin
                        state_q <= OWN1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OWN0, OWN1: begin
                    if (xfer_s && own_last_s) begin
                        state_q <= IDLE;
                        last_q  <= (state_q == OWN1);
                        tmo_q   <= 8'd0;
                    end else if (own_valid_s) begin
                        tmo_q <= 8'd0;
                    end else if (bus.fifo_full) begin
                        // A stalled FIFO is not the requester's fault: hold the count.
                        tmo_q <= tmo_q;
                    end else if (tmo_q == TO_LIM) begin
                        state_q <= IDLE;
                        last_q  <= (state_q == OWN1);
                        tmo_q   <= 8'd0;
                        abort_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tmo_q   <= 8'd0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_CNT_EN
    logic [7:0] cnt0_q;
    logic [7:0] cnt1_q;

    // Accepted-word counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            if (xfer_s && (state_q == OWN0)) begin
                cnt0_q <= cnt0_q + 8'd1;
            end
            if (xfer_s && (state_q == OWN1)) begin
                cnt1_q <= cnt1_q + 8'd1;
            end
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
`else
    assign bus.cnt0 = 8'd0;
    assign bus.cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single packet, tie alternation, FIFO stall,
// idle timeout with a waiting requester, reset mid-packet and the 300-word counter wrap.
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fifo_wr_arbiter_if #(.B(8)) bus ();

    fifo_wr_arbiter #(.B(8), .TO(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int n);
`ifdef FIFO_ARB_CNT_EN
        return 32'(n % 256);
`else
        return 32'(n * 0);
`endif
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
        bus.fifo_full  = 1'b0;

        // Reset state
        next(); next(); settle();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_wr", 32'(bus.fifo_wr), 32'h0);
        chk("rst_rdy0", 32'(bus.req0_ready), 32'h0);
        next(); reset = 1'b0; settle();
        chk("idle_grant", 32'(bus.grant), 32'h0);
        chk("idle_abort", 32'(bus.abort), 32'h0);
        chk("idle_cnt0", 32'(bus.cnt0), 32'h0);
        chk("idle_cnt1", 32'(bus.cnt1), 32'h0);

        // Single 3-word packet from req0
        next(); bus.req0_valid = 1'b1; bus.req0_data = 8'hA1; settle();
        chk("p1_arb_grant", 32'(bus.grant), 32'h0);
        chk("p1_arb_wr", 32'(bus.fifo_wr), 32'h0);
        chk("p1_arb_rdy0", 32'(bus.req0_ready), 32'h0);
        next(); settle();
        chk("p1_grant", 32'(bus.grant), 32'h1);
        chk("p1_wr1", 32'(bus.fifo_wr), 32'h1);
        chk("p1_d1", 32'(bus.fifo_wdata), 32'hA1);
        chk("p1_rdy1_off", 32'(bus.req1_ready), 32'h0);
        next(); bus.req0_data = 8'hA2; settle();
        chk("p1_wr2", 32'(bus.fifo_wr), 32'h1);
        chk("p1_d2", 32'(bus.fifo_wdata), 32'hA2);
        next(); bus.req0_data = 8'hA3; bus.req0_last = 1'b1; settle();
        chk("p1_wr3", 32'(bus.fifo_wr), 32'h1);
        chk("p1_d3", 32'(bus.fifo_wdata), 32'hA3);
        next(); bus.req0_valid = 1'b0; bus.req0_last = 1'b0; settle();
        chk("p1_end_grant", 32'(bus.grant), 32'h0);
        chk("p1_end_wr", 32'(bus.fifo_wr), 32'h0);
        chk("p1_end_wdata", 32'(bus.fifo_wdata), 32'h0);
        chk("p1_cnt0", 32'(bus.cnt0), cexp(3));

        // Tie after reset: req0 first, then req1; repeated tie serves req0 again
        next(); reset = 1'b1; settle();
        next(); reset = 1'b0; settle();
        chk("tie_rst_cnt0", 32'(bus.cnt0), 32'h0);
        next();
        bus.req0_valid = 1'b1; bus.req0_data = 8'hB0; bus.req0_last = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_data = 8'hC0; bus.req1_last = 1'b1;
        settle();
        chk("tie1_arb", 32'(bus.grant), 32'h0);
        next(); settle();
        chk("tie1_grant0", 32'(bus.grant), 32'h1);
        chk("tie1_d0", 32'(bus.fifo_wdata), 32'hB0);
        chk("tie1_rdy1_held", 32'(bus.req1_ready), 32'h0);
        next(); bus.req0_valid = 1'b0; settle();
        chk("tie1_gap", 32'(bus.grant), 32'h0);
        next(); settle();
        chk("tie1_grant1", 32'(bus.grant), 32'h2);
        chk("tie1_d1", 32'(bus.fifo_wdata), 32'hC0);
        chk("tie1_rdy1", 32'(bus.req1_ready), 32'h1);
        chk("tie1_rdy0_off", 32'(bus.req0_ready), 32'h0);
        next(); bus.req1_valid = 1'b0; settle();
        chk("tie1_end", 32'(bus.grant), 32'h0);
        next(); bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; settle();
        next(); settle();
        chk("tie2_grant0", 32'(bus.grant), 32'h1);
        chk("tie2_d0", 32'(bus.fifo_wdata), 32'hB0);
        next(); bus.req0_valid = 1'b0; settle();
        next(); settle();
        chk("tie2_grant1", 32'(bus.grant), 32'h2);
        next(); bus.req1_valid = 1'b0; settle();
        chk("tie2_end", 32'(bus.grant), 32'h0);
        chk("tie_cnt0", 32'(bus.cnt0), cexp(2));
        chk("tie_cnt1", 32'(bus.cnt1), cexp(2));
        bus.req0_last = 1'b0; bus.req1_last = 1'b0;

        // FIFO full for 5 cycles mid-packet
        next(); bus.req0_valid = 1'b1; bus.req0_data = 8'hD1; settle();
        next(); settle();
        chk("full_d1", 32'(bus.fifo_wdata), 32'hD1);
        chk("full_wr1", 32'(bus.fifo_wr), 32'h1);
        for (int k = 0; k < 5; k++) begin
            next(); bus.req0_data = 8'hD2; bus.fifo_full = 1'b1; settle();
            chk("full_wr0", 32'(bus.fifo_wr), 32'h0);
            chk("full_rdy0", 32'(bus.req0_ready), 32'h0);
            chk("full_abort", 32'(bus.abort), 32'h0);
            chk("full_grant", 32'(bus.grant), 32'h1);
        end
        next(); bus.fifo_full = 1'b0; settle();
        chk("full_resume_wr", 32'(bus.fifo_wr), 32'h1);
        chk("full_resume_d", 32'(bus.fifo_wdata), 32'hD2);
        chk("full_resume_rdy", 32'(bus.req0_ready), 32'h1);
        next(); bus.req0_data = 8'hD3; bus.req0_last = 1'b1; settle();
        chk("full_d3", 32'(bus.fifo_wdata), 32'hD3);
        next(); bus.req0_valid = 1'b0; bus.req0_last = 1'b0; settle();
        chk("full_end", 32'(bus.grant), 32'h0);
        chk("full_cnt0", 32'(bus.cnt0), cexp(5));

        // Idle timeout with req1 waiting
        next(); bus.req0_valid = 1'b1; bus.req0_data = 8'hE1; settle();
        next();
        bus.req1_valid = 1'b1; bus.req1_data = 8'hF1; bus.req1_last = 1'b1;
        settle();
        chk("to_wr", 32'(bus.fifo_wr), 32'h1);
        next(); bus.req0_valid = 1'b0; settle();
        chk("to_idle1_grant", 32'(bus.grant), 32'h1);
        chk("to_idle1_abort", 32'(bus.abort), 32'h0);
        chk("to_idle1_rdy1", 32'(bus.req1_ready), 32'h0);
        for (int k = 2; k <= 16; k++) begin
            next(); settle();
            chk("to_hold_grant", 32'(bus.grant), 32'h1);
            chk("to_hold_abort", 32'(bus.abort), 32'h0);
        end
        next(); settle();
        chk("to_abort", 32'(bus.abort), 32'h1);
        chk("to_abort_grant", 32'(bus.grant), 32'h0);
        next(); settle();
        chk("to_abort_once", 32'(bus.abort), 32'h0);
        chk("to_next_grant", 32'(bus.grant), 32'h2);
        chk("to_next_d", 32'(bus.fifo_wdata), 32'hF1);
        next(); bus.req1_valid = 1'b0; bus.req1_last = 1'b0; settle();
        chk("to_end", 32'(bus.grant), 32'h0);

        // Reset during OWN1, then 300 words from req0
        next(); bus.req1_valid = 1'b1; bus.req1_data = 8'h61; settle();
        next(); settle();
        chk("rs_own1", 32'(bus.grant), 32'h2);
        next(); reset = 1'b1; settle();
        chk("rs_during_wr", 32'(bus.fifo_wr), 32'h0);
        chk("rs_during_rdy1", 32'(bus.req1_ready), 32'h0);
        next(); reset = 1'b0; bus.req1_valid = 1'b0; settle();
        chk("rs_grant", 32'(bus.grant), 32'h0);
        chk("rs_cnt0", 32'(bus.cnt0), 32'h0);
        chk("rs_cnt1", 32'(bus.cnt1), 32'h0);
        next(); bus.req0_valid = 1'b1; bus.req0_data = 8'h00; settle();
        next();
        for (int i = 0; i < 300; i++) begin
            bus.req0_data = 8'(i);
            bus.req0_last = (i == 299);
            settle();
            if ((i % 50) == 0 || i == 299) begin
                chk("w300_wr", 32'(bus.fifo_wr), 32'h1);
                chk("w300_d", 32'(bus.fifo_wdata), 32'(i % 256));
            end
            next();
        end
        bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
        settle();
        chk("w300_end", 32'(bus.grant), 32'h0);
        chk("w300_cnt0", 32'(bus.cnt0), cexp(300));
        chk("w300_cnt1", 32'(bus.cnt1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
